// File: rtl/mem_port_master.sv
// mem_port_master: single-outstanding request master for one memory port.
// Converts a valid/ready request into en/wen/addr/data memory signalling,
// waits out the registered busy flag (with an optional timeout on reads) and
// returns read data or an error through a valid/ready response channel.
// All memory-side and response-side outputs come straight from flops.
module mem_port_master #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] MEMSIZE     = 32'h0001_0000,
    parameter int unsigned TIMEOUT_MAX = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_en_o,
    output logic        mem_wen_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic        mem_busy_i,
    input  logic [31:0] mem_data_i
);

    localparam int unsigned WAIT_W = (TIMEOUT_MAX > 0) ? $clog2(TIMEOUT_MAX + 1) : 1;
    // Counter value seen on the busy cycle that makes TIMEOUT_MAX in a row.
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((TIMEOUT_MAX == 0) ? 0 : TIMEOUT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RADDR,
        S_RWAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               en_q, en_d;
    logic               wen_q, wen_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;

    logic [32:0]        addr_ext;
    logic [32:0]        range_lo;
    logic [32:0]        range_hi;
    logic               addr_bad;
    logic               timeout_hit;

    // Range check is done in 33 bits so BASE_ADDR+MEMSIZE cannot wrap.
    assign addr_ext = {1'b0, req_addr_i};
    assign range_lo = {1'b0, BASE_ADDR};
    assign range_hi = {1'b0, BASE_ADDR} + {1'b0, MEMSIZE};
    assign addr_bad = (req_addr_i[1:0] != 2'b00) || (addr_ext < range_lo) ||
                      (addr_ext >= range_hi);

    assign timeout_hit = (TIMEOUT_MAX != 0) && (wait_q == WAIT_LAST);

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign mem_en_o    = en_q;
    assign mem_wen_o   = wen_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = data_q;

    // State, wait counter and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            en_q        <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            en_q        <= en_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next state and next values of the registered outputs. The memory-side
    // signals are computed one state ahead so they are valid from the first
    // cycle of WRITE/RADDR and drop on entry to RESP.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        en_d        = en_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (addr_bad) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        // Memory sees the byte offset from BASE_ADDR.
                        addr_d = req_addr_i - BASE_ADDR;
                        en_d   = 1'b1;
                        if (req_we_i) begin
                            wen_d   = 1'b1;
                            data_d  = req_wdata_i;
                            state_d = S_WRITE;
                        end else begin
                            wen_d   = 1'b0;
                            state_d = S_RADDR;
                        end
                    end
                end
            end
            S_WRITE: begin
                en_d        = 1'b0;
                wen_d       = 1'b0;
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            S_RADDR: begin
                wait_d  = '0;
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (!mem_busy_i) begin
                    en_d        = 1'b0;
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = mem_data_i;
                end else if (timeout_hit) begin
                    en_d        = 1'b0;
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                wen_d   = 1'b0;
            end
        endcase
    end

endmodule
